filter_mem_loader: RTL and testbench

Streams filter coefficients, one byte at a time, into the 32-bit-word filter memory that feeds the convolution datapath.
- Packs each group of 4 bytes into one word and issues one write per word.
- Lane order matches the filter memory read side: byte address 4w+k is returned on read lane k.
- Runs under a start/done handshake from the layer controller; the controller issues one load per filter bank before each layer.

---
 rtl/filter_mem_pkg.sv | 18 +
 rtl/filter_mem_loader_if.sv | 27 ++
 rtl/filter_byte_packer.sv | 53 +++++
 rtl/filter_mem_loader.sv | 143 ++++++++++++++
 tb/tb_filter_mem_loader.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/filter_mem_pkg.sv
// Definitions shared by the filter memory loader and the filter memory read side.
// Lane k of a memory word carries byte address 4w+k in bits [31-8k -: 8].
package filter_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = 8;

  function automatic int lane_msb(input int k);
    return 31 - LANE_W * k;
  endfunction

endpackage

// File: rtl/filter_mem_loader_if.sv
// Loader bus: start/len command, byte stream in (valid/ready), word writes and status out.
// The master side is the layer controller plus the byte source; the slave side is the loader.
interface filter_mem_loader_if #(
  parameter int NO_BITS = 8
);
  logic               start;
  logic [NO_BITS:0]   len;
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               wr_en;
  logic [NO_BITS-3:0] wr_addr;
  logic [31:0]        wr_data;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, len, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done, err
  );

  modport slave (
    input  start, len, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/filter_byte_packer.sv
// Four-lane byte packer: per-lane load, clear, zero-padded merged word for the byte being loaded.
// Word output is combinational (0 cycles); no backpressure, the loader gates load.
module filter_byte_packer
  import filter_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic        flush,
  input  logic [1:0]  lane,
  input  logic [7:0]  byte_in,
  output logic [31:0] word
);

  logic [BYTES_PER_WORD-1:0][7:0] lanes_q, lanes_d;
  logic [BYTES_PER_WORD-1:0]      lane_en;

  always_comb begin
    lane_en = '0;
    if (load) lane_en[lane] = 1'b1;
  end

  // A flushed word leaves the register empty so the next word starts zero-padded.
  always_comb begin
    lanes_d = lanes_q;
    if (clr || (load && flush)) begin
      lanes_d = '0;
    end else begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        if (lane_en[k]) lanes_d[k] = byte_in;
      end
    end
  end

  // Lanes above the incoming byte are forced to zero for a short final word.
  always_comb begin
    word = '0;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (2'(k) < lane) begin
        word[lane_msb(k) -: 8] = lanes_q[k];
      end else if (2'(k) == lane) begin
        word[lane_msb(k) -: 8] = byte_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) lanes_q <= '0;
    else     lanes_q <= lanes_d;
  end

endmodule

// File: rtl/filter_mem_loader.sv
// Streams coefficient bytes into 32-bit filter memory words under a start/done handshake.
// Byte-to-write latency 1 cycle; in_ready is high only in FILL, gaps in in_valid just stall.
module filter_mem_loader
  import filter_mem_pkg::*;
#(
  parameter int CAPACITY = 64,
  parameter int NO_BITS  = 8
) (
  input logic                clk,
  input logic                rst,
  filter_mem_loader_if.slave bus
);

  typedef logic [NO_BITS:0]   len_t;
  typedef logic [NO_BITS-3:0] waddr_t;

  localparam len_t MAX_LEN = len_t'(BYTES_PER_WORD * CAPACITY);

  state_t      state_q, state_d;
  len_t        len_q, len_d;
  len_t        byte_cnt_q, byte_cnt_d;
  waddr_t      word_cnt_q, word_cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        wr_en_q, wr_en_d;
  waddr_t      wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;

  logic        accept;
  logic        last_byte;
  logic        word_full;
  logic        pk_clr;
  logic        pk_flush;
  logic [1:0]  lane;
  logic [31:0] pk_word;

  assign lane      = byte_cnt_q[1:0];
  assign accept    = (state_q == FILL) && bus.in_valid;
  assign last_byte = (byte_cnt_q == len_q - 1'b1);
  assign word_full = (lane == 2'd3);
  assign pk_flush  = word_full || last_byte;

  filter_byte_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .clr     (pk_clr),
    .load    (accept),
    .flush   (pk_flush),
    .lane    (lane),
    .byte_in (bus.in_data),
    .word    (pk_word)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    pk_clr     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len == '0) begin
            state_d = DONE;
          end else if (bus.len > MAX_LEN) begin
            err_d = 1'b1;
          end else begin
            len_d      = bus.len;
            byte_cnt_d = '0;
            word_cnt_d = '0;
            pk_clr     = 1'b1;
            busy_d     = 1'b1;
            state_d    = FILL;
          end
        end
      end
      FILL: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (pk_flush) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = word_cnt_q;
            wr_data_d  = pk_word;
            word_cnt_d = word_cnt_q + 1'b1;
          end
          // in_ready falls together with the final write strobe.
          if (last_byte) begin
            busy_d  = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign bus.in_ready = (state_q == FILL);
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_filter_mem_loader.sv
// Bench for filter_mem_loader: scenario tasks drive loads and compare observed writes
// against words built directly from the byte list.
module tb_filter_mem_loader;

  localparam int CAPACITY = 64;
  localparam int NO_BITS  = 8;
  localparam int MAXB     = 4 * CAPACITY;

  logic clk;
  logic rst;

  filter_mem_loader_if #(.NO_BITS(NO_BITS)) bus ();

  filter_mem_loader #(.CAPACITY(CAPACITY), .NO_BITS(NO_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cyc = 0;
  bit busy_seen = 0;

  logic [7:0]  mem [0:MAXB-1];
  int          acc_at [0:MAXB-1];
  int          wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          wr_cyc_q [$];
  int          done_cyc_q [$];
  int          err_cyc_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wr_addr_q.push_back(int'(bus.wr_addr));
      wr_data_q.push_back(bus.wr_data);
      wr_cyc_q.push_back(cyc);
    end
    if (bus.done === 1'b1) done_cyc_q.push_back(cyc);
    if (bus.err === 1'b1)  err_cyc_q.push_back(cyc);
    if (bus.busy === 1'b1) busy_seen = 1'b1;
  end

  // Word w of a load of n bytes: byte 4w+k sits in lane k, missing bytes read as zero.
  function automatic logic [31:0] model_word(input int w, input int n);
    logic [31:0] r;
    r = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (4 * w + k < n) r = r | (32'(mem[4 * w + k]) << (8 * (3 - k)));
    end
    return r;
  endfunction

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_cyc_q.delete();
    err_cyc_q.delete();
    busy_seen = 1'b0;
  endtask

  task automatic start_load(input int n);
    clear_mon();
    bus.len   = (NO_BITS + 1)'(n);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic feed(input int n, input bit gaps, input int poke);
    int   idx;
    int   guard;
    bit   v;
    logic rdy;
    idx = 0;
    guard = 0;
    while (idx < n && guard < 4000) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_valid = v;
      bus.in_data  = v ? mem[idx] : 8'($urandom);
      if (idx == poke && v) begin
        bus.start = 1'b1;
        bus.len   = (NO_BITS + 1)'(2);
      end
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (v && rdy === 1'b1) begin
        acc_at[idx] = cyc;
        idx++;
      end
      guard++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_cycles(3);
    @(negedge clk);
    vectors++;
    if ({bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.done, bus.err} !== '0) begin
      miscompares++;
      $display("FAIL reset outputs: got rdy=%b wr_en=%b addr=%h data=%h busy=%b done=%b err=%b, want all 0",
               bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.done, bus.err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_full_word();
    int n, nw, lastb;
    n = 8;
    for (int i = 0; i < n; i++) mem[i] = 8'h11 + 8'(i);
    start_load(n);
    feed(n, 1'b0, -1);
    idle_cycles(6);
    nw = (n + 3) / 4;
    vectors++;
    if (wr_cyc_q.size() != nw) begin
      miscompares++;
      $display("FAIL full_word wr_en count: got %0d want %0d", wr_cyc_q.size(), nw);
    end
    for (int w = 0; w < nw && w < wr_cyc_q.size(); w++) begin
      lastb = (4 * w + 3 < n) ? 4 * w + 3 : n - 1;
      vectors++;
      if (wr_addr_q[w] != w || wr_data_q[w] !== model_word(w, n) || wr_cyc_q[w] != acc_at[lastb]) begin
        miscompares++;
        $display("FAIL full_word write %0d: got addr %0d data %h cyc %0d, want addr %0d data %h cyc %0d",
                 w, wr_addr_q[w], wr_data_q[w], wr_cyc_q[w], w, model_word(w, n), acc_at[lastb]);
      end
    end
    vectors++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != acc_at[n - 1] + 1) begin
      miscompares++;
      $display("FAIL full_word done: got %0d pulses (first cyc %0d), want 1 at cyc %0d",
               done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1, acc_at[n - 1] + 1);
    end
    vectors++;
    if (busy_seen !== 1'b1) begin
      miscompares++;
      $display("FAIL full_word busy: got never high, want high during load");
    end
  endtask

  task automatic test_partial_word();
    int n, nw, lastb;
    n = 6;
    for (int i = 0; i < n; i++) mem[i] = 8'hA0 + 8'(i);
    start_load(n);
    feed(n, 1'b0, -1);
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL partial in_ready after last byte: got %b want 0", bus.in_ready);
    end
    idle_cycles(6);
    nw = (n + 3) / 4;
    vectors++;
    if (wr_cyc_q.size() != nw) begin
      miscompares++;
      $display("FAIL partial wr_en count: got %0d want %0d", wr_cyc_q.size(), nw);
    end
    for (int w = 0; w < nw && w < wr_cyc_q.size(); w++) begin
      lastb = (4 * w + 3 < n) ? 4 * w + 3 : n - 1;
      vectors++;
      if (wr_addr_q[w] != w || wr_data_q[w] !== model_word(w, n) || wr_cyc_q[w] != acc_at[lastb]) begin
        miscompares++;
        $display("FAIL partial write %0d: got addr %0d data %h cyc %0d, want addr %0d data %h cyc %0d",
                 w, wr_addr_q[w], wr_data_q[w], wr_cyc_q[w], w, model_word(w, n), acc_at[lastb]);
      end
    end
  endtask

  task automatic test_gaps();
    bit   pat [7];
    int   idx;
    logic rdy;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
    start_load(4);
    idx = 0;
    for (int p = 0; p < 7; p++) begin
      bus.in_valid = pat[p];
      bus.in_data  = pat[p] ? mem[idx] : 8'($urandom);
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk); #1;
      if (pat[p] && rdy === 1'b1 && idx < 4) begin
        acc_at[idx] = cyc;
        idx++;
      end
    end
    bus.in_valid = 1'b0;
    idle_cycles(6);
    vectors++;
    if (wr_cyc_q.size() != 1) begin
      miscompares++;
      $display("FAIL gaps wr_en count: got %0d want 1", wr_cyc_q.size());
    end else begin
      vectors++;
      if (wr_addr_q[0] != 0 || wr_data_q[0] !== model_word(0, 4) || wr_cyc_q[0] != acc_at[3]) begin
        miscompares++;
        $display("FAIL gaps write: got addr %0d data %h cyc %0d, want addr 0 data %h cyc %0d",
                 wr_addr_q[0], wr_data_q[0], wr_cyc_q[0], model_word(0, 4), acc_at[3]);
      end
    end
  endtask

  task automatic test_len_zero();
    start_load(0);
    idle_cycles(5);
    vectors++;
    if (done_cyc_q.size() != 1 || wr_cyc_q.size() != 0 || busy_seen) begin
      miscompares++;
      $display("FAIL len_zero: got %0d done, %0d writes, busy_seen %b; want 1 done, 0 writes, busy 0",
               done_cyc_q.size(), wr_cyc_q.size(), busy_seen);
    end
  endtask

  task automatic test_len_over();
    start_load(MAXB + 1);
    idle_cycles(5);
    vectors++;
    if (err_cyc_q.size() != 1 || err_cyc_q[0] != start_cyc) begin
      miscompares++;
      $display("FAIL len_over err: got %0d pulses (first cyc %0d), want 1 at cyc %0d",
               err_cyc_q.size(), (err_cyc_q.size() > 0) ? err_cyc_q[0] : -1, start_cyc);
    end
    vectors++;
    if (busy_seen || wr_cyc_q.size() != 0 || done_cyc_q.size() != 0) begin
      miscompares++;
      $display("FAIL len_over side effects: got busy_seen %b, %0d writes, %0d done; want 0, 0, 0",
               busy_seen, wr_cyc_q.size(), done_cyc_q.size());
    end
  endtask

  task automatic test_len_max();
    int n, nw, bad;
    n = MAXB;
    for (int i = 0; i < n; i++) mem[i] = 8'($urandom);
    start_load(n);
    feed(n, 1'b0, -1);
    idle_cycles(6);
    nw = n / 4;
    bad = 0;
    vectors++;
    if (wr_cyc_q.size() != nw) begin
      miscompares++;
      $display("FAIL len_max wr_en count: got %0d want %0d", wr_cyc_q.size(), nw);
    end
    for (int w = 0; w < nw && w < wr_cyc_q.size(); w++) begin
      if (wr_addr_q[w] != w || wr_data_q[w] !== model_word(w, n) || wr_cyc_q[w] != acc_at[4 * w + 3]) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL len_max words: got %0d wrong writes, want 0", bad);
    end
    vectors++;
    if (wr_addr_q.size() == 0 || wr_addr_q[wr_addr_q.size() - 1] != CAPACITY - 1) begin
      miscompares++;
      $display("FAIL len_max last addr: got %0d want %0d",
               (wr_addr_q.size() > 0) ? wr_addr_q[wr_addr_q.size() - 1] : -1, CAPACITY - 1);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
    start_load(8);
    feed(5, 1'b0, -1);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.done, bus.err} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid outputs: got rdy=%b wr_en=%b addr=%h data=%h busy=%b done=%b err=%b, want all 0",
               bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.done, bus.err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(4);
    vectors++;
    if (wr_cyc_q.size() != 1 || done_cyc_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_mid aborted load: got %0d writes %0d done, want 1 write 0 done",
               wr_cyc_q.size(), done_cyc_q.size());
    end
    for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
    start_load(4);
    feed(4, 1'b0, -1);
    idle_cycles(5);
    vectors++;
    if (wr_cyc_q.size() != 1 || wr_addr_q[0] != 0 || wr_data_q[0] !== model_word(0, 4)) begin
      miscompares++;
      $display("FAIL reset_mid reload: got %0d writes, first addr %0d data %h; want 1 write addr 0 data %h",
               wr_cyc_q.size(), (wr_addr_q.size() > 0) ? wr_addr_q[0] : -1,
               (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hx, model_word(0, 4));
    end
  endtask

  task automatic test_start_while_busy();
    int n, nw, lastb;
    n = 8;
    for (int i = 0; i < n; i++) mem[i] = 8'($urandom);
    start_load(n);
    feed(n, 1'b0, 2);
    idle_cycles(6);
    nw = (n + 3) / 4;
    vectors++;
    if (wr_cyc_q.size() != nw || done_cyc_q.size() != 1 || err_cyc_q.size() != 0) begin
      miscompares++;
      $display("FAIL start_busy counts: got %0d writes %0d done %0d err, want %0d 1 0",
               wr_cyc_q.size(), done_cyc_q.size(), err_cyc_q.size(), nw);
    end
    for (int w = 0; w < nw && w < wr_cyc_q.size(); w++) begin
      lastb = (4 * w + 3 < n) ? 4 * w + 3 : n - 1;
      vectors++;
      if (wr_addr_q[w] != w || wr_data_q[w] !== model_word(w, n) || wr_cyc_q[w] != acc_at[lastb]) begin
        miscompares++;
        $display("FAIL start_busy write %0d: got addr %0d data %h cyc %0d, want addr %0d data %h cyc %0d",
                 w, wr_addr_q[w], wr_data_q[w], wr_cyc_q[w], w, model_word(w, n), acc_at[lastb]);
      end
    end
  endtask

  task automatic test_random();
    int n, nw, lastb;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 48);
      for (int i = 0; i < n; i++) mem[i] = 8'($urandom);
      start_load(n);
      feed(n, 1'b1, -1);
      idle_cycles(6);
      nw = (n + 3) / 4;
      vectors++;
      if (wr_cyc_q.size() != nw) begin
        miscompares++;
        $display("FAIL random[%0d] len %0d wr_en count: got %0d want %0d", it, n, wr_cyc_q.size(), nw);
      end
      for (int w = 0; w < nw && w < wr_cyc_q.size(); w++) begin
        lastb = (4 * w + 3 < n) ? 4 * w + 3 : n - 1;
        vectors++;
        if (wr_addr_q[w] != w || wr_data_q[w] !== model_word(w, n) || wr_cyc_q[w] != acc_at[lastb]) begin
          miscompares++;
          $display("FAIL random[%0d] write %0d: got addr %0d data %h cyc %0d, want addr %0d data %h cyc %0d",
                   it, w, wr_addr_q[w], wr_data_q[w], wr_cyc_q[w], w, model_word(w, n), acc_at[lastb]);
        end
      end
      vectors++;
      if (done_cyc_q.size() != 1 || done_cyc_q[0] != acc_at[n - 1] + 1) begin
        miscompares++;
        $display("FAIL random[%0d] done: got %0d pulses (first cyc %0d), want 1 at cyc %0d",
                 it, done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1, acc_at[n - 1] + 1);
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.len      = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    test_reset();
    test_full_word();
    test_partial_word();
    test_gaps();
    test_len_zero();
    test_len_over();
    test_len_max();
    test_reset_mid();
    test_start_while_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
